keypad_event_fifo: RTL and testbench

- Downstream consumer of the matrix-keypad scanner.
- Turns the scanner's held key code plus key-down level into discrete, debounced key-press events.
- Queues events in a small FIFO for the CPU peripheral bus to pop.
- Provides status (empty, full, count), a sticky overflow flag and a level interrupt request, so software never misses or double-counts a press.

---
 rtl/keypad_event_fifo_if.sv | 28 ++
 rtl/keypad_event_fifo.sv | 162 ++++++++++++++++
 tb/tb_keypad_event_fifo.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_event_fifo_if.sv
// Keypad event FIFO bus interface.
// Scanner inputs, CPU pop/flush strobes and FIFO status outputs.
interface keypad_event_fifo_if #(
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [3:0]    key_val;
    logic          key_down;
    logic          rd_en;
    logic          clr;
    logic [3:0]    dout;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
    logic          overflow;
    logic          irq;

    modport master (
        output key_val, key_down, rd_en, clr,
        input  dout, empty, full, count, overflow, irq
    );

    modport slave (
        input  key_val, key_down, rd_en, clr,
        output dout, empty, full, count, overflow, irq
    );
endinterface

// File: rtl/keypad_event_fifo.sv
// Keypad event FIFO: debounces scanner key-down into press events
// Ports: clk, rst (async high), bus (slave): key_val/key_down in,
//   rd_en/clr in, dout/empty/full/count/overflow/irq out.
module keypad_event_fifo #(
    parameter int DEPTH           = 8,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
    input logic                clk,
    input logic                rst,
    keypad_event_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CW-1:0]    CNT_FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_CHK,
        HELD,
        RELEASE_CHK
    } state_t;

    // two-flop synchronisers
    logic       kd_m, kd_s;
    logic [3:0] kv_m, kv_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kd_m <= 1'b0;
            kd_s <= 1'b0;
            kv_m <= 4'h0;
            kv_s <= 4'h0;
        end else begin
            kd_m <= bus.key_down;
            kd_s <= kd_m;
            kv_m <= bus.key_val;
            kv_s <= kv_m;
        end
    end

    // debounce FSM
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RELEASED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        push    = 1'b0;
        unique case (state_q)
            RELEASED: begin
                if (kd_s) begin
                    state_d = PRESS_CHK;
                    cnt_d   = CNT_ONE;
                end
            end
            PRESS_CHK: begin
                if (!kd_s) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    push    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!kd_s) begin
                    state_d = RELEASE_CHK;
                    cnt_d   = CNT_ONE;
                end
            end
            RELEASE_CHK: begin
                if (kd_s) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    // event FIFO
    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count_q;
    logic          ovf_q;
    logic          empty, full, pop, wr;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_FULL);
    assign pop   = bus.rd_en & ~empty;
    // a full FIFO still accepts a push when the head leaves this cycle
    assign wr    = push & (~full | pop);

    always_ff @(posedge clk) begin
        if (wr && !bus.clr) begin
            mem[wr_ptr] <= kv_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else if (bus.clr) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !wr) begin
                count_q <= count_q - 1'b1;
            end
            if (push && full && !pop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign bus.dout     = empty ? 4'h0 : mem[rd_ptr];
    assign bus.empty    = empty;
    assign bus.full     = full;
    assign bus.count    = count_q;
    assign bus.overflow = ovf_q;
    assign bus.irq      = ~empty;
endmodule

// File: tb/tb_keypad_event_fifo.sv
// Testbench for keypad_event_fifo.
// Scenario tasks plus random stimulus against a queue-based model.
module tb_keypad_event_fifo;
    localparam int DEPTH = 8;
    localparam int DB    = 16;
    localparam logic [11:0] RST_VEC =
        {4'h0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vecs = 0;
    int   errs = 0;

    always #5 clk = ~clk;

    keypad_event_fifo_if #(.DEPTH(DEPTH)) kif ();

    keypad_event_fifo #(
        .DEPTH(DEPTH),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(kif.slave)
    );

    wire [11:0] got = {kif.dout, kif.empty, kif.full,
                       kif.count, kif.overflow, kif.irq};

    // reference model: press accepted after DB consecutive
    // synchronised samples that disagree with the accepted level
    bit         s1, s2;
    logic [3:0] v1, v2;
    bit         held;
    int         run;
    logic [3:0] q[$];
    bit         ovf;

    task automatic model_reset();
        s1 = 0; s2 = 0; v1 = 0; v2 = 0;
        held = 0; run = 0; ovf = 0;
        q.delete();
    endtask

    task automatic model_step();
        bit         ev;
        logic [3:0] code;
        if (rst) begin
            model_reset();
            return;
        end
        ev   = 0;
        code = v2;
        if (s2 != held) run++;
        else run = 0;
        if (run == DB) begin
            held = s2;
            run  = 0;
            ev   = held;
        end
        s2 = s1; s1 = kif.key_down;
        v2 = v1; v1 = kif.key_val;
        if (kif.clr) begin
            q.delete();
            ovf = 0;
        end else begin
            if (kif.rd_en && q.size() != 0) void'(q.pop_front());
            if (ev) begin
                if (q.size() < DEPTH) q.push_back(code);
                else ovf = 1;
            end
        end
    endtask

    function automatic logic [11:0] exp_vec();
        logic [3:0] d;
        d = (q.size() != 0) ? q[0] : 4'h0;
        return {d, q.size() == 0, q.size() == DEPTH,
                4'(q.size()), ovf, q.size() != 0};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic seg(input bit kd, input logic [3:0] kv,
                       input bit rd, input bit c, input int n);
        kif.key_down = kd;
        kif.key_val  = kv;
        kif.rd_en    = rd;
        kif.clr      = c;
        repeat (n) tick();
        kif.rd_en = 0;
        kif.clr   = 0;
    endtask

    task automatic press(input logic [3:0] kv);
        seg(1, kv, 0, 0, 20);
        seg(0, kv, 0, 0, 20);
    endtask

    task automatic test_reset();
        kif.key_down = 0; kif.key_val = 0;
        kif.rd_en = 0; kif.clr = 0;
        rst = 1;
        repeat (3) tick();
        vecs++;
        if (got !== RST_VEC) begin
            errs++;
            $display("FAIL reset: got %h want %h", got, RST_VEC);
        end
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_clean_press();
        kif.key_down = 1; kif.key_val = 4'h7;
        for (int i = 0; i < 40; i++) begin
            tick();
            vecs++;
            if (got !== exp_vec()) begin
                errs++;
                $display("FAIL clean_model e%0d: got %h want %h",
                         i, got, exp_vec());
            end
            if (i == 16) begin
                vecs++;
                if (kif.empty !== 1'b1) begin
                    errs++;
                    $display("FAIL clean_early: empty %b want 1",
                             kif.empty);
                end
            end
            if (i == 17) begin
                vecs++;
                if ({kif.empty, kif.dout, kif.count, kif.irq}
                    !== {1'b0, 4'h7, 4'd1, 1'b1}) begin
                    errs++;
                    $display("FAIL clean_event: got %h want 0711",
                             {kif.empty, kif.dout, kif.count,
                              kif.irq});
                end
            end
        end
        seg(0, 4'h7, 0, 0, 20);
        seg(0, 4'h7, 1, 0, 1);
        vecs++;
        if ({kif.empty, kif.dout} !== 5'b1_0000 ||
            got !== exp_vec()) begin
            errs++;
            $display("FAIL clean_pop: got %h want %h",
                     got, exp_vec());
        end
    endtask

    task automatic test_bounce();
        seg(1, 4'hA, 0, 0, 5);
        seg(0, 4'hA, 0, 0, 3);
        seg(1, 4'hA, 0, 0, 30);
        vecs++;
        if (kif.count !== 4'd1 || kif.dout !== 4'hA ||
            got !== exp_vec()) begin
            errs++;
            $display("FAIL bounce_press: got %h want %h",
                     got, exp_vec());
        end
        seg(0, 4'hA, 0, 0, 5);
        seg(1, 4'hA, 0, 0, 4);
        seg(0, 4'hA, 0, 0, 20);
        press(4'h3);
        vecs++;
        if (kif.count !== 4'd2 || kif.dout !== 4'hA ||
            got !== exp_vec()) begin
            errs++;
            $display("FAIL bounce_release: got %h want %h",
                     got, exp_vec());
        end
        seg(0, 4'h0, 1, 0, 1);
        vecs++;
        if (kif.dout !== 4'h3 || kif.count !== 4'd1) begin
            errs++;
            $display("FAIL bounce_order: got %h want dout 3 cnt 1",
                     got);
        end
        seg(0, 4'h0, 1, 0, 1);
    endtask

    task automatic test_overflow();
        for (int c = 0; c < 9; c++) begin
            press(4'(c));
            if (c == 7) begin
                vecs++;
                if (kif.full !== 1'b1 || kif.overflow !== 1'b0) begin
                    errs++;
                    $display("FAIL ovf_full: got %h want full", got);
                end
            end
        end
        vecs++;
        if (kif.overflow !== 1'b1 || kif.count !== 4'd8 ||
            got !== exp_vec()) begin
            errs++;
            $display("FAIL ovf_set: got %h want %h", got, exp_vec());
        end
        for (int i = 0; i < 8; i++) begin
            vecs++;
            if (kif.dout !== 4'(i)) begin
                errs++;
                $display("FAIL ovf_pop%0d: got %h want %h",
                         i, kif.dout, 4'(i));
            end
            seg(0, 4'h0, 1, 0, 1);
        end
        vecs++;
        if (kif.empty !== 1'b1 || kif.overflow !== 1'b1) begin
            errs++;
            $display("FAIL ovf_sticky: got %h want empty+ovf", got);
        end
        seg(0, 4'h0, 0, 1, 1);
        vecs++;
        if (got !== RST_VEC) begin
            errs++;
            $display("FAIL ovf_clr: got %h want %h", got, RST_VEC);
        end
    endtask

    task automatic test_full_pop();
        for (int c = 1; c <= 8; c++) press(4'(c));
        seg(1, 4'h9, 0, 0, 17);
        seg(1, 4'h9, 1, 0, 1);
        vecs++;
        if (kif.count !== 4'd8 || kif.overflow !== 1'b0 ||
            kif.dout !== 4'h2 || got !== exp_vec()) begin
            errs++;
            $display("FAIL fullpop: got %h want %h", got, exp_vec());
        end
        seg(0, 4'h9, 0, 0, 20);
        seg(0, 4'h0, 1, 0, 7);
        vecs++;
        if (kif.dout !== 4'h9 || kif.count !== 4'd1) begin
            errs++;
            $display("FAIL fullpop_last: got %h want dout 9", got);
        end
        seg(0, 4'h0, 1, 0, 1);
    endtask

    task automatic test_clr_priority();
        seg(1, 4'h5, 0, 0, 17);
        seg(1, 4'h5, 0, 1, 1);
        vecs++;
        if (got !== RST_VEC || got !== exp_vec()) begin
            errs++;
            $display("FAIL clr_push: got %h want %h", got, RST_VEC);
        end
        seg(1, 4'h5, 0, 0, 30);
        vecs++;
        if (kif.empty !== 1'b1) begin
            errs++;
            $display("FAIL clr_held: got %h want empty", got);
        end
        seg(0, 4'h5, 0, 0, 20);
        press(4'h6);
        vecs++;
        if (kif.count !== 4'd1 || kif.dout !== 4'h6) begin
            errs++;
            $display("FAIL clr_repress: got %h want dout 6", got);
        end
        seg(0, 4'h0, 1, 0, 1);
    endtask

    task automatic test_async_reset();
        press(4'h1); press(4'h2); press(4'h3);
        seg(1, 4'h4, 0, 0, 12);
        #2 rst = 1;
        model_reset();
        #1;
        vecs++;
        if (got !== RST_VEC) begin
            errs++;
            $display("FAIL arst_async: got %h want %h", got, RST_VEC);
        end
        repeat (2) tick();
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            vecs++;
            if (got !== exp_vec()) begin
                errs++;
                $display("FAIL arst_model e%0d: got %h want %h",
                         i, got, exp_vec());
            end
            if (i == 16 || i == 17) begin
                vecs++;
                if (kif.empty !== (i == 16) ||
                    (i == 17 && kif.dout !== 4'h4)) begin
                    errs++;
                    $display("FAIL arst_event e%0d: got %h", i, got);
                end
            end
        end
        seg(0, 4'h4, 0, 0, 20);
        seg(0, 4'h0, 1, 0, 1);
    endtask

    task automatic test_random();
        int left = 0;
        bit kd = 0;
        logic [3:0] kv = 0;
        for (int i = 0; i < 3000; i++) begin
            if (left == 0) begin
                kd   = ~kd;
                left = $urandom_range(1, 24);
                kv   = 4'($urandom_range(0, 15));
            end
            left--;
            if ($urandom_range(0, 30) == 0) kv = 4'($urandom);
            kif.key_down = kd;
            kif.key_val  = kv;
            kif.rd_en = ($urandom_range(0, i < 1500 ? 40 : 4) == 0);
            kif.clr   = ($urandom_range(0, 299) == 0);
            tick();
            vecs++;
            if (got !== exp_vec()) begin
                errs++;
                $display("FAIL random c%0d: got %h want %h",
                         i, got, exp_vec());
            end
        end
        kif.rd_en = 0;
        kif.clr   = 0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_clean_press();
        test_bounce();
        test_overflow();
        test_full_pop();
        test_clr_priority();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vecs, errs);
        $finish;
    end
endmodule
